// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame serializer: default sizes, FSM states
// and the per-frame channel array type.
package adc_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [DATA_W_DEF-1:0] frame_t [N_CH_DEF];

endpackage

// File: rtl/ch_next_sel.sv
// Finds the lowest enabled channel at or above i_cur, and whether any enabled
// channel lies beyond it (o_last means none does).
module ch_next_sel #(
  parameter int  N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_mask,
  input  logic [CH_W:0]   i_cur,
  output logic [CH_W-1:0] o_idx,
  output logic            o_found,
  output logic            o_last
);

  // Scanning downward leaves the lowest hit in o_idx; o_last survives only
  // if that hit was the sole one.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    o_last  = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (i_mask[k] && (k >= int'(i_cur))) begin
        o_last  = !o_found;
        o_found = 1'b1;
        o_idx   = CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/adc_frame_serializer.sv
// Accepts one N_CH-wide ADC frame at a time and emits its enabled channels as
// a word stream in ascending channel order, with valid/ready on both sides.
module adc_frame_serializer
  import adc_pkg::*;
#(
  parameter int  N_CH   = N_CH_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data [N_CH],
  input  logic [N_CH-1:0]   ch_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  input  logic              clr_ovr
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_data [N_CH];
  logic [N_CH-1:0]     r_mask;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [CH_W-1:0]     r_out_ch;
  logic                r_out_last;
  logic [15:0]         r_frame_cnt;
  logic                r_ovr;

  logic                w_done;
  logic                w_accept;
  logic                w_load;
  logic                w_adv;
  logic                w_drain;
  logic [CH_W-1:0]     w_first_idx;
  logic                w_first_found;
  logic                w_first_last;
  logic [CH_W:0]       w_nxt_start;
  logic [CH_W-1:0]     w_nxt_idx;
  logic                w_nxt_found;
  logic                w_nxt_last;

  assign w_done      = r_out_valid && out_ready && r_out_last;
  assign in_ready    = (r_state == IDLE) || w_done;
  assign w_accept    = in_valid && in_ready;
  assign w_nxt_start = {1'b0, r_out_ch} + {{CH_W{1'b0}}, 1'b1};

  // First word of a new frame comes from the live inputs; later words from the held copy.
  ch_next_sel #(.N_CH(N_CH)) u_first_sel (
    .i_mask  (ch_mask),
    .i_cur   ('0),
    .o_idx   (w_first_idx),
    .o_found (w_first_found),
    .o_last  (w_first_last)
  );

  ch_next_sel #(.N_CH(N_CH)) u_next_sel (
    .i_mask  (r_mask),
    .i_cur   (w_nxt_start),
    .o_idx   (w_nxt_idx),
    .o_found (w_nxt_found),
    .o_last  (w_nxt_last)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_first_found) begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (r_out_last) begin
            if (w_accept && w_first_found) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_drain     = 1'b1;
            end
          end else if (w_nxt_found) begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Set of overrun takes priority over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_frame_cnt <= '0;
      r_ovr       <= 1'b0;
      r_mask      <= '0;
      for (int k = 0; k < N_CH; k++) r_data[k] <= '0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_mask <= ch_mask;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_first_idx];
        r_out_ch    <= w_first_idx;
        r_out_last  <= w_first_last;
      end else if (w_adv) begin
        r_out_data  <= r_data[w_nxt_idx];
        r_out_ch    <= w_nxt_idx;
        r_out_last  <= w_nxt_last;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
      if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (in_valid && !in_ready) r_ovr <= 1'b1;
      else if (clr_ovr)          r_ovr <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Directed bench for adc_frame_serializer: full/sparse masks, stalls,
// back-to-back frames, overrun stickiness and mid-frame reset.
module tb_adc_frame_serializer;
  import adc_pkg::*;

  localparam int N_CH   = N_CH_DEF;
  localparam int DATA_W = DATA_W_DEF;
  localparam int CH_W   = $clog2(N_CH);

  logic              CLK = 1'b0;
  logic              nRST;
  logic              in_valid;
  logic              in_ready;
  frame_t            in_data;
  logic [N_CH-1:0]   ch_mask;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;
  logic [15:0]       frame_cnt;
  logic              overrun;
  logic              clr_ovr;

  int n_chk = 0;
  int n_err = 0;
  int rdy_seq [6] = '{1, 0, 0, 1, 1, 1};
  int ch_seq  [6] = '{0, 1, 1, 1, 2, 3};

  adc_frame_serializer #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ch_mask   (ch_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .frame_cnt (frame_cnt),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] wd(input logic [15:0] tag, input int k);
    return {tag, 48'(k)};
  endfunction

  function automatic frame_t mk(input logic [15:0] tag);
    frame_t f;
    for (int k = 0; k < N_CH; k++) f[k] = wd(tag, k);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] ftag, input int ch, input bit last);
    chk({tag, "_vld"},  64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, wd(ftag, ch));
    chk({tag, "_ch"},   64'(out_ch), 64'(ch));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_vld"},   64'(out_valid), 64'd0);
    chk({tag, "_data"},  out_data, 64'd0);
    chk({tag, "_ch"},    64'(out_ch), 64'd0);
    chk({tag, "_last"},  64'(out_last), 64'd0);
    chk({tag, "_fcnt"},  64'(frame_cnt), 64'd0);
    chk({tag, "_ovr"},   64'(overrun), 64'd0);
    chk({tag, "_irdy"},  64'(in_ready), 64'd1);
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_data = mk(16'h0000); ch_mask = '0;
    out_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    chk_reset_state("rst");
    nRST = 1'b1;

    // full mask, continuous ready; inputs scrambled after acceptance
    in_valid = 1'b1; in_data = mk(16'hA000); ch_mask = 4'b1111;
    #1 chk("t1_irdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_data = mk(16'hDEAD); ch_mask = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk_word("t1", 16'hA000, k, k == 3);
      tick();
    end
    chk("t1_idle", 64'(out_valid), 64'd0);
    chk("t1_fcnt", 64'(frame_cnt), 64'd1);

    // sparse mask skips disabled channels
    in_valid = 1'b1; in_data = mk(16'hB000); ch_mask = 4'b1010;
    tick();
    in_valid = 1'b0;
    chk_word("t2a", 16'hB000, 1, 1'b0);
    tick();
    chk_word("t2b", 16'hB000, 3, 1'b1);
    tick();
    chk("t2_idle", 64'(out_valid), 64'd0);
    chk("t2_fcnt", 64'(frame_cnt), 64'd2);

    // downstream stalls hold the word
    in_valid = 1'b1; in_data = mk(16'hC000); ch_mask = 4'b1111;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy_seq[i][0];
      chk_word("t3", 16'hC000, ch_seq[i], ch_seq[i] == 3);
      tick();
    end
    out_ready = 1'b1;
    chk("t3_idle", 64'(out_valid), 64'd0);
    chk("t3_fcnt", 64'(frame_cnt), 64'd3);

    // back-to-back frames with in_valid held high
    in_valid = 1'b1; in_data = mk(16'hD000); ch_mask = 4'b1111;
    tick();
    in_data = mk(16'hE000);
    for (int k = 0; k < 4; k++) begin
      chk_word("t4a", 16'hD000, k, k == 3);
      chk("t4_irdy", 64'(in_ready), 64'(k == 3));
      tick();
    end
    in_valid = 1'b0; in_data = mk(16'hDEAD);
    for (int k = 0; k < 4; k++) begin
      chk_word("t4b", 16'hE000, k, k == 3);
      tick();
    end
    chk("t4_fcnt", 64'(frame_cnt), 64'd5);
    chk("t4_ovr", 64'(overrun), 64'd1);

    // overrun sticky behaviour and set-beats-clear
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("t5_clr", 64'(overrun), 64'd0);
    in_valid = 1'b1; in_data = mk(16'hF000); ch_mask = 4'b0011;
    tick();
    out_ready = 1'b0;
    tick();
    chk("t5_set", 64'(overrun), 64'd1);
    chk_word("t5_hold", 16'hF000, 0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("t5_sticky", 64'(overrun), 64'd1);
    in_valid = 1'b1; clr_ovr = 1'b1;
    tick();
    chk("t5_both", 64'(overrun), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("t5_clr2", 64'(overrun), 64'd0);
    clr_ovr = 1'b0; out_ready = 1'b1;
    chk_word("t5a", 16'hF000, 0, 1'b0);
    tick();
    chk_word("t5b", 16'hF000, 1, 1'b1);
    tick();
    chk("t5_idle", 64'(out_valid), 64'd0);
    chk("t5_fcnt", 64'(frame_cnt), 64'd6);

    // reset in the middle of a frame
    in_valid = 1'b1; in_data = mk(16'h6000); ch_mask = 4'b1111;
    tick();
    in_valid = 1'b0;
    chk_word("t6a", 16'h6000, 0, 1'b0);
    tick();
    chk_word("t6b", 16'h6000, 1, 1'b0);
    tick();
    nRST = 1'b0;
    tick();
    chk_reset_state("t6_rst");
    nRST = 1'b1;
    in_valid = 1'b1; in_data = mk(16'h7000); ch_mask = 4'b0110;
    tick();
    in_valid = 1'b0;
    chk_word("t6c", 16'h7000, 1, 1'b0);
    tick();
    chk_word("t6d", 16'h7000, 2, 1'b1);
    tick();
    chk("t6_fcnt", 64'(frame_cnt), 64'd1);

    // empty mask produces nothing; single channel is always last
    in_valid = 1'b1; in_data = mk(16'h8000); ch_mask = 4'b0000;
    #1 chk("t7_irdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("t7_vld", 64'(out_valid), 64'd0);
    chk("t7_fcnt", 64'(frame_cnt), 64'd1);
    chk("t7_irdy2", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = mk(16'h9000); ch_mask = 4'b1000;
    tick();
    in_valid = 1'b0;
    chk_word("t8", 16'h9000, 3, 1'b1);
    tick();
    chk("t8_idle", 64'(out_valid), 64'd0);
    chk("t8_fcnt", 64'(frame_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_frame_serializer.md
ADC_FRAME_SERIALIZER -- requirements
Module: adc_frame_serializer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of parallel ADC channels per frame, 2..16.
REQ-002 SHALL have parameter DATA_W, default 64: width of each channel word.
REQ-003 SHALL have port CLK, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port nRST, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: frame available on in_data.
REQ-006 SHALL have port in_ready, output, 1: frame accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, N_CH x DATA_W: unpacked array; element k is channel k.
REQ-008 SHALL have port ch_mask, input, N_CH: channel enable; bit k=1 serializes channel k; sampled with the frame.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_ch/out_last valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, DATA_W: serialized channel word.
REQ-012 SHALL have port out_ch, output, clog2(N_CH): channel index of out_data.
REQ-013 SHALL have port out_last, output, 1: last enabled channel of the frame.
REQ-014 SHALL have port frame_cnt, output, 16: completed frames, wraps 0xFFFF->0.
REQ-015 SHALL have port overrun, output, 1: sticky; set when in_valid && !in_ready.
REQ-016 SHALL have port clr_ovr, input, 1: clears overrun; a set in the same cycle wins.

Function
REQ-017 SHALL use states IDLE (no frame held) and SHIFT (frame held, words pending).
REQ-018 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_last), combinationally.
REQ-019 SHALL, on acceptance, latch in_data and ch_mask, and present the lowest enabled channel on the next cycle: 1-cycle latency.
REQ-020 SHALL emit enabled channels in ascending index order and skip disabled channels with no idle cycles.
REQ-021 SHALL hold out_data, out_ch, out_last and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL advance to the next enabled channel on each out_valid && out_ready; one word per cycle at full throughput.
REQ-023 SHALL, on acceptance of the last word, increment frame_cnt and go to SHIFT with the new frame if one is accepted in that cycle, giving back-to-back frames with no bubble; otherwise go to IDLE.
REQ-024 SHALL accept a frame whose ch_mask==0, produce no output for it, stay or return to IDLE, and not increment frame_cnt.
REQ-025 SHALL assert out_last on every word of a frame with exactly one enabled channel.
REQ-026 SHALL ignore changes to in_data and ch_mask after a frame has been accepted.

Reset
REQ-027 SHALL, when nRST=0 at a clock edge, set state=IDLE, out_valid=0, out_data=0, out_ch=0, out_last=0, frame_cnt=0, overrun=0, and clear the held frame and mask.
REQ-028 SHALL, on reset during SHIFT, discard the in-flight frame; in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-029 SHALL place DATA_W/N_CH defaults, the state enum, and the frame typedef (array of N_CH x DATA_W) in shared package adc_pkg.
REQ-030 SHALL implement next-channel selection in sub-module ch_next_sel: combinational; inputs are mask and current index; outputs are the next enabled index and an is_last flag.

Verification
REQ-031 SHALL check this case: N_CH=4, mask=1111, frame {A0,A1,A2,A3}, out_ready=1 -> A0..A3 on 4 consecutive cycles starting 1 cycle after acceptance, out_ch 0..3, out_last only on A3, frame_cnt=1.
REQ-032 SHALL check this case: mask=1010 -> only A1 (ch1) then A3 (ch3, last), on consecutive cycles.
REQ-033 SHALL check this case: out_ready toggling 1,0,0,1 during a frame -> the word is held unchanged through stall cycles, and no word is lost or duplicated.
REQ-034 SHALL check this case: two frames back-to-back with in_valid held high -> in_ready pulses on the last-word cycle, B0 follows A3 with no gap, and frame_cnt=2.
REQ-035 SHALL check this case: in_valid high during SHIFT before the last word -> overrun=1 and stays set until clr_ovr; with clr_ovr and a new overrun in the same cycle, overrun stays 1.
REQ-036 SHALL check this case: nRST=0 mid-frame after the 2nd word -> all outputs are at reset values next cycle, in_ready=1, and the next frame starts from its lowest enabled channel.
